// File: rtl/spi_master_if.sv
// Request and pin bundle for spi_master: the sequencer-side request/response signals and the
// four chip-level SPI pins.
interface spi_master_if;
  logic        start;
  logic [7:0]  instr;
  logic [15:0] addr;
  logic [7:0]  wdata;
  logic        busy;
  logic        done;
  logic [7:0]  rdata;
  logic        SCLK;
  logic        MOSI;
  logic        SS;
  logic        MISO;

  modport master (
    input  start, instr, addr, wdata, MISO,
    output busy, done, rdata, SCLK, MOSI, SS
  );

  modport slave (
    output start, instr, addr, wdata, MISO,
    input  busy, done, rdata, SCLK, MOSI, SS
  );
endinterface

// File: rtl/spi_master.sv
// SPI mode-0 initiator: one request shifts a fixed 32-bit frame {instr, addr, wdata} MSB first
// and returns the MISO byte seen during the final data byte.
module spi_master #(
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned SS_GUARD = 2
) (
  input  logic         clk,
  input  logic         reset_n,
  spi_master_if.master bus
);

  localparam logic [7:0] DivLast   = 8'(CLK_DIV - 1);
  localparam logic [7:0] GuardLast = 8'(SS_GUARD - 1);

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StHigh,
    StLow,
    StHold,
    StGap
  } state_e;

  state_e      state_q;
  logic [7:0]  phase_q;
  logic [4:0]  bit_q;
  logic [31:0] frame_q;
  logic [7:0]  cap_q;
  logic [7:0]  rdata_q;
  logic        sclk_q;
  logic        mosi_q;
  logic        ss_q;
  logic        busy_q;
  logic        done_q;

  logic [7:0]  phase_last;
  logic        phase_end;

  // SCLK half-periods use CLK_DIV; every SS-related interval uses SS_GUARD.
  always_comb begin
    phase_last = GuardLast;
    if (state_q == StHigh || state_q == StLow) begin
      phase_last = DivLast;
    end
  end

  assign phase_end = (phase_q == phase_last);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      phase_q <= 8'd0;
      bit_q   <= 5'd0;
      frame_q <= 32'd0;
      cap_q   <= 8'd0;
      rdata_q <= 8'd0;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      ss_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      phase_q <= phase_end ? 8'd0 : phase_q + 8'd1;
      unique case (state_q)
        StIdle: begin
          phase_q <= 8'd0;
          if (bus.start) begin
            frame_q <= {bus.instr, bus.addr, bus.wdata};
            mosi_q  <= bus.instr[7];
            ss_q    <= 1'b0;
            busy_q  <= 1'b1;
            bit_q   <= 5'd0;
            state_q <= StSetup;
          end
        end
        StSetup: begin
          if (phase_end) begin
            sclk_q  <= 1'b1;
            cap_q   <= {cap_q[6:0], bus.MISO};
            state_q <= StHigh;
          end
        end
        StHigh: begin
          if (phase_end) begin
            sclk_q <= 1'b0;
            if (bit_q == 5'd31) begin
              state_q <= StHold;
            end else begin
              // Falling edge: present the next frame bit.
              frame_q <= {frame_q[30:0], 1'b0};
              mosi_q  <= frame_q[30];
              bit_q   <= bit_q + 5'd1;
              state_q <= StLow;
            end
          end
        end
        StLow: begin
          if (phase_end) begin
            sclk_q  <= 1'b1;
            cap_q   <= {cap_q[6:0], bus.MISO};
            state_q <= StHigh;
          end
        end
        StHold: begin
          if (phase_end) begin
            ss_q    <= 1'b1;
            done_q  <= 1'b1;
            rdata_q <= cap_q;
            state_q <= StGap;
          end
        end
        StGap: begin
          if (phase_end) begin
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.SCLK  = sclk_q;
  assign bus.MOSI  = mosi_q;
  assign bus.SS    = ss_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.rdata = rdata_q;

endmodule

// File: tb/tb_spi_master.sv
// Self-checking bench for spi_master: default-parameter instance with a pattern-driving slave,
// plus a CLK_DIV=1/SS_GUARD=1 instance with MISO looped back from MOSI.
module tb_spi_master;
  localparam int G  = 2;
  localparam int D  = 4;
  localparam int GM = 1;
  localparam int DM = 1;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  spi_master_if bus ();
  spi_master_if bus_m ();

  spi_master #(.CLK_DIV(D), .SS_GUARD(G)) u_dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.master)
  );

  spi_master #(.CLK_DIV(DM), .SS_GUARD(GM)) u_min (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_m.master)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Observation of the default instance, sampled on the falling clk edge.
  bit         rise_bits[$];
  int         rise_cyc[$];
  int         ss_fall[$];
  int         ss_rise[$];
  int         busy_rise[$];
  int         busy_fall[$];
  int         done_cyc[$];
  logic [7:0] done_rdata[$];
  logic       mosi_log[int];
  logic       prev_sclk = 1'b0;
  logic       prev_ss = 1'b1;
  logic       prev_busy = 1'b0;

  always @(negedge clk) begin
    if (!prev_sclk && bus.SCLK) begin
      rise_bits.push_back(bus.MOSI);
      rise_cyc.push_back(cyc);
    end
    if (prev_ss && !bus.SS) ss_fall.push_back(cyc);
    if (!prev_ss && bus.SS) ss_rise.push_back(cyc);
    if (!prev_busy && bus.busy) busy_rise.push_back(cyc);
    if (prev_busy && !bus.busy) busy_fall.push_back(cyc);
    if (bus.done) begin
      done_cyc.push_back(cyc);
      done_rdata.push_back(bus.rdata);
    end
    mosi_log[cyc] = bus.MOSI;
    prev_sclk = bus.SCLK;
    prev_ss = bus.SS;
    prev_busy = bus.busy;
  end

  // Slave: presents miso_pat MSB first, advancing after each SCLK fall.
  logic [31:0] miso_pat = 32'hFFFF_FFFF;
  int          sidx = 0;
  logic        s_prev_sclk = 1'b0;

  always @(negedge clk) begin
    if (bus.SS) sidx = 0;
    else if (s_prev_sclk && !bus.SCLK && sidx < 31) sidx++;
    s_prev_sclk = bus.SCLK;
    bus.MISO = miso_pat[31-sidx];
  end

  // Minimum-parameter instance: loopback retimed on the falling clk edge.
  bit         m_bits[$];
  int         m_ss_low = 0;
  int         m_done = 0;
  logic [7:0] m_rdata = 8'h00;
  logic       m_prev_sclk = 1'b0;

  always @(negedge clk) begin
    if (!m_prev_sclk && bus_m.SCLK) m_bits.push_back(bus_m.MOSI);
    if (!bus_m.SS) m_ss_low++;
    if (bus_m.done) begin
      m_done++;
      m_rdata = bus_m.rdata;
    end
    m_prev_sclk = bus_m.SCLK;
    bus_m.MISO = bus_m.MOSI;
  end

  task automatic clear_mon();
    rise_bits.delete();
    rise_cyc.delete();
    ss_fall.delete();
    ss_rise.delete();
    busy_rise.delete();
    busy_fall.delete();
    done_cyc.delete();
    done_rdata.delete();
  endtask

  task automatic start_frame(input logic [7:0] i, input logic [15:0] a, input logic [7:0] w,
                             output int t0);
    @(negedge clk);
    bus.instr = i;
    bus.addr  = a;
    bus.wdata = w;
    bus.start = 1'b1;
    t0 = cyc;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int n, input int budget, output bit timed_out);
    timed_out = 1'b1;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (done_cyc.size() >= n) begin
        timed_out = 1'b0;
        break;
      end
    end
    repeat (G + 2) @(negedge clk);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    logic [12:0] obs;
    @(negedge clk);
    obs = {bus.SS, bus.SCLK, bus.MOSI, bus.busy, bus.done, bus.rdata};
    vectors++;
    if (obs !== {5'b10000, 8'h00}) begin
      miscompares++;
      $display("FAIL reset_state: got %b want %b", obs, {5'b10000, 8'h00});
    end
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    obs = {bus_m.SS, bus_m.SCLK, bus_m.MOSI, bus_m.busy, bus_m.done, bus_m.rdata};
    vectors++;
    if (obs !== {5'b10000, 8'h00}) begin
      miscompares++;
      $display("FAIL reset_state_min: got %b want %b", obs, {5'b10000, 8'h00});
    end
  endtask

  task automatic test_write_frame();
    logic [7:0]  i, w;
    logic [15:0] a;
    logic [31:0] exp_f, got_f;
    int t0, bad, r;
    bit to;
    for (int n = 0; n < 3; n++) begin
      if (n == 0) begin
        i = 8'h01; a = 16'h0004; w = 8'h3C;
      end else begin
        i = 8'($urandom); a = 16'($urandom); w = 8'($urandom);
      end
      miso_pat = $urandom;
      exp_f = {i, a, w};
      clear_mon();
      start_frame(i, a, w, t0);
      wait_done(1, 400, to);
      vectors++;
      if (to) begin
        miscompares++;
        $display("FAIL wr_timeout[%0d]: no done in 400 cycles", n);
      end
      got_f = '0;
      for (int k = 0; k < rise_bits.size() && k < 32; k++) got_f = {got_f[30:0], rise_bits[k]};
      vectors++;
      if (rise_bits.size() != 32 || got_f !== exp_f) begin
        miscompares++;
        $display("FAIL wr_bits[%0d]: got %h (%0d rises) want %h (32 rises)", n, got_f,
                 rise_bits.size(), exp_f);
      end
      bad = -1;
      for (int k = 0; k < rise_cyc.size(); k++)
        if (bad < 0 && rise_cyc[k] != t0 + 1 + G + 2 * k * D) bad = k;
      vectors++;
      if (bad != -1) begin
        miscompares++;
        $display("FAIL wr_rise_time[%0d]: bit %0d at %0d want %0d", n, bad, rise_cyc[bad],
                 t0 + 1 + G + 2 * bad * D);
      end
      vectors++;
      if (ss_fall.size() != 1 || ss_rise.size() != 1 || ss_fall[0] != t0 + 1 ||
          ss_rise[0] - ss_fall[0] != 256) begin
        miscompares++;
        $display("FAIL wr_ss_low[%0d]: fell %0d rose %0d want fell %0d low 256", n,
                 ss_fall.size() > 0 ? ss_fall[0] : -1, ss_rise.size() > 0 ? ss_rise[0] : -1,
                 t0 + 1);
      end
      vectors++;
      if (done_cyc.size() != 1 || done_cyc[0] != t0 + 257) begin
        miscompares++;
        $display("FAIL wr_done[%0d]: %0d pulses first at %0d want 1 at %0d", n, done_cyc.size(),
                 done_cyc.size() > 0 ? done_cyc[0] - t0 : -1, 257);
      end
      vectors++;
      if (done_rdata.size() != 1 || done_rdata[0] !== miso_pat[7:0]) begin
        miscompares++;
        $display("FAIL wr_rdata[%0d]: got %h want %h", n,
                 done_rdata.size() > 0 ? done_rdata[0] : 8'hxx, miso_pat[7:0]);
      end
      vectors++;
      if (busy_rise.size() != 1 || busy_fall.size() != 1 || busy_rise[0] != t0 + 1 ||
          busy_fall[0] != t0 + 257 + G) begin
        miscompares++;
        $display("FAIL wr_busy[%0d]: rose %0d fell %0d want %0d %0d", n,
                 busy_rise.size() > 0 ? busy_rise[0] : -1,
                 busy_fall.size() > 0 ? busy_fall[0] : -1, t0 + 1, t0 + 257 + G);
      end
      // MOSI must hold D cycles after each rise (and D before, except bit 0's SETUP lead-in).
      bad = -1;
      for (int k = 0; k < rise_cyc.size(); k++) begin
        r = rise_cyc[k];
        for (int c = (k == 0 ? r : r - D); c < r + D; c++)
          if (bad < 0 && mosi_log[c] !== rise_bits[k]) bad = k;
      end
      vectors++;
      if (bad != -1) begin
        miscompares++;
        $display("FAIL wr_mosi_stable[%0d]: bit %0d moved within %0d cycles of its rise", n, bad,
                 D);
      end
    end
  endtask

  task automatic test_read_back();
    int t0;
    bit to;
    pulse_reset();
    miso_pat = {24'hFF_FFFF, 8'hA5};
    clear_mon();
    start_frame(8'h03, 16'h0004, 8'h00, t0);
    to = 1'b1;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (rise_bits.size() >= 30) begin
        to = 1'b0;
        break;
      end
    end
    vectors++;
    if (to || bus.rdata !== 8'h00) begin
      miscompares++;
      $display("FAIL rd_before_done: got %h timeout %0d want 00", bus.rdata, to);
    end
    wait_done(1, 200, to);
    vectors++;
    if (to || done_rdata.size() != 1 || done_rdata[0] !== 8'hA5) begin
      miscompares++;
      $display("FAIL rd_at_done: got %h (%0d dones) want a5",
               done_rdata.size() > 0 ? done_rdata[0] : 8'hxx, done_rdata.size());
    end
    repeat (20) @(negedge clk);
    vectors++;
    if (bus.rdata !== 8'hA5) begin
      miscompares++;
      $display("FAIL rd_hold: got %h want a5", bus.rdata);
    end
  endtask

  task automatic test_busy_reject();
    logic [7:0]  i, w;
    logic [15:0] a;
    logic [31:0] got_f;
    int t0;
    bit to;
    i = 8'($urandom); a = 16'($urandom); w = 8'($urandom);
    miso_pat = $urandom;
    clear_mon();
    start_frame(i, a, w, t0);
    while (cyc < t0 + 50) @(negedge clk);
    bus.instr = ~i; bus.addr = ~a; bus.wdata = ~w; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(1, 400, to);
    repeat (40) @(negedge clk);
    got_f = '0;
    for (int k = 0; k < rise_bits.size() && k < 32; k++) got_f = {got_f[30:0], rise_bits[k]};
    vectors++;
    if (to || rise_bits.size() != 32 || got_f !== {i, a, w}) begin
      miscompares++;
      $display("FAIL busy_frame: got %h (%0d rises) want %h", got_f, rise_bits.size(), {i, a, w});
    end
    vectors++;
    if (done_cyc.size() != 1 || ss_fall.size() != 1) begin
      miscompares++;
      $display("FAIL busy_single: got %0d dones %0d frames want 1 1", done_cyc.size(),
               ss_fall.size());
    end
    vectors++;
    if (done_rdata.size() != 1 || done_rdata[0] !== miso_pat[7:0]) begin
      miscompares++;
      $display("FAIL busy_rdata: got %h want %h", done_rdata.size() > 0 ? done_rdata[0] : 8'hxx,
               miso_pat[7:0]);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] f1, f2, g1, g2;
    int t0;
    bit to;
    f1 = $urandom;
    f2 = $urandom;
    miso_pat = $urandom;
    clear_mon();
    @(negedge clk);
    bus.instr = f1[31:24]; bus.addr = f1[23:8]; bus.wdata = f1[7:0]; bus.start = 1'b1;
    t0 = cyc;
    repeat (5) @(negedge clk);
    bus.instr = f2[31:24]; bus.addr = f2[23:8]; bus.wdata = f2[7:0];
    for (int k = 0; k < 400 && ss_fall.size() < 2; k++) @(negedge clk);
    bus.start = 1'b0;
    wait_done(2, 400, to);
    g1 = '0;
    g2 = '0;
    for (int k = 0; k < rise_bits.size() && k < 64; k++)
      if (k < 32) g1 = {g1[30:0], rise_bits[k]};
      else g2 = {g2[30:0], rise_bits[k]};
    vectors++;
    if (to || rise_bits.size() != 64 || g1 !== f1 || g2 !== f2) begin
      miscompares++;
      $display("FAIL b2b_frames: got %h %h (%0d rises) want %h %h", g1, g2, rise_bits.size(), f1,
               f2);
    end
    vectors++;
    if (done_cyc.size() != 2 || done_rdata.size() != 2 || done_rdata[0] !== miso_pat[7:0] ||
        done_rdata[1] !== miso_pat[7:0]) begin
      miscompares++;
      $display("FAIL b2b_done: got %0d dones want 2 with rdata %h", done_cyc.size(),
               miso_pat[7:0]);
    end
    vectors++;
    if (ss_fall.size() < 2 || ss_rise.size() < 1 || ss_fall[1] - ss_rise[0] != G + 1 ||
        ss_fall[1] != t0 + 2 + 3 * G + 63 * D) begin
      miscompares++;
      $display("FAIL b2b_gap: gap %0d second fall %0d want gap %0d fall %0d",
               (ss_fall.size() > 1 && ss_rise.size() > 0) ? ss_fall[1] - ss_rise[0] : -1,
               ss_fall.size() > 1 ? ss_fall[1] : -1, G + 1, t0 + 2 + 3 * G + 63 * D);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [12:0] obs;
    logic [31:0] f, got_f;
    int t0;
    bit to;
    miso_pat = $urandom;
    clear_mon();
    start_frame(8'($urandom), 16'($urandom), 8'($urandom), t0);
    to = 1'b1;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (rise_bits.size() >= 13) begin
        to = 1'b0;
        break;
      end
    end
    #1 reset_n = 1'b0;
    #1 obs = {bus.SS, bus.SCLK, bus.MOSI, bus.busy, bus.done, bus.rdata};
    vectors++;
    if (to || obs[12:8] !== 5'b10000) begin
      miscompares++;
      $display("FAIL mid_reset_state: got %b want 10000 (timeout %0d)", obs[12:8], to);
    end
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (300) @(negedge clk);
    vectors++;
    if (done_cyc.size() != 0) begin
      miscompares++;
      $display("FAIL mid_reset_no_done: got %0d dones want 0", done_cyc.size());
    end
    f = $urandom;
    clear_mon();
    start_frame(f[31:24], f[23:8], f[7:0], t0);
    wait_done(1, 400, to);
    got_f = '0;
    for (int k = 0; k < rise_bits.size() && k < 32; k++) got_f = {got_f[30:0], rise_bits[k]};
    vectors++;
    if (to || rise_bits.size() != 32 || got_f !== f || done_cyc.size() != 1 ||
        done_cyc[0] != t0 + 257 || done_rdata[0] !== miso_pat[7:0]) begin
      miscompares++;
      $display("FAIL mid_reset_next: got %h (%0d rises, %0d dones) want %h", got_f,
               rise_bits.size(), done_cyc.size(), f);
    end
  endtask

  task automatic test_min_params();
    logic [31:0] f, got_f;
    bit to;
    for (int n = 0; n < 3; n++) begin
      f = $urandom;
      m_bits.delete();
      m_ss_low = 0;
      m_done = 0;
      @(negedge clk);
      bus_m.instr = f[31:24]; bus_m.addr = f[23:8]; bus_m.wdata = f[7:0]; bus_m.start = 1'b1;
      @(negedge clk);
      bus_m.start = 1'b0;
      to = 1'b1;
      for (int k = 0; k < 200; k++) begin
        @(negedge clk);
        if (m_done >= 1) begin
          to = 1'b0;
          break;
        end
      end
      repeat (4) @(negedge clk);
      got_f = '0;
      for (int k = 0; k < m_bits.size() && k < 32; k++) got_f = {got_f[30:0], m_bits[k]};
      vectors++;
      if (to || m_bits.size() != 32 || got_f !== f) begin
        miscompares++;
        $display("FAIL min_bits[%0d]: got %h (%0d rises) want %h", n, got_f, m_bits.size(), f);
      end
      vectors++;
      if (m_ss_low != 2 * GM + 63 * DM) begin
        miscompares++;
        $display("FAIL min_ss_low[%0d]: got %0d want %0d", n, m_ss_low, 2 * GM + 63 * DM);
      end
      vectors++;
      if (m_done != 1 || m_rdata !== f[7:0]) begin
        miscompares++;
        $display("FAIL min_rdata[%0d]: got %h (%0d dones) want %h", n, m_rdata, m_done, f[7:0]);
      end
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.instr = 8'h00;
    bus.addr = 16'h0000;
    bus.wdata = 8'h00;
    bus_m.start = 1'b0;
    bus_m.instr = 8'h00;
    bus_m.addr = 16'h0000;
    bus_m.wdata = 8'h00;
    repeat (3) @(negedge clk);
    test_reset();
    test_read_back();
    test_write_frame();
    test_busy_reject();
    test_back_to_back();
    test_reset_mid_frame();
    test_min_params();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
